// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time. It debounces
//   both press and release and registers exactly one hex digit per physical
//   press. The two most recent digits drive a dual 7-segment display directly.
//
// Ports
//   clk         : system clock, rising edge
//   reset       : synchronous active-low reset
//   rows        : keypad rows, active-low, asynchronous (synchronized here)
//   cols        : column drive, active-low, one-hot-low
//   s1          : previously entered digit
//   s2          : most recently entered digit
//   key_valid   : one-cycle pulse on each accepted press
//   dbg_state_o : current FSM state (0 SCAN, 1 PRESS_DB, 2 HELD, 3 REL_DB)
//
// Handshake: key_valid is a single-cycle strobe with no ready/back-pressure.
//   s1/s2 are updated on the same edge and are stable whenever key_valid is high.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 4800,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic       key_valid,
  output logic [1:0] dbg_state_o
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, rs_q;
  logic [3:0]    cols_q, cols_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] dbcnt_q, dbcnt_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic          key_valid_q, key_valid_d;

  logic          detect;
  logic [3:0]    cols_next;

  // Row i / column j to digit. When several rows are low, the lowest row wins.
  function automatic logic [3:0] decode(input logic [3:0] pat,
                                        input logic [3:0] colv);
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] dig;
    if (!pat[0])      r = 2'd0;
    else if (!pat[1]) r = 2'd1;
    else if (!pat[2]) r = 2'd2;
    else              r = 2'd3;
    if (!colv[0])      c = 2'd0;
    else if (!colv[1]) c = 2'd1;
    else if (!colv[2]) c = 2'd2;
    else               c = 2'd3;
    case ({r, c})
      4'h0: dig = 4'h1;  4'h1: dig = 4'h2;  4'h2: dig = 4'h3;  4'h3: dig = 4'hA;
      4'h4: dig = 4'h4;  4'h5: dig = 4'h5;  4'h6: dig = 4'h6;  4'h7: dig = 4'hB;
      4'h8: dig = 4'h7;  4'h9: dig = 4'h8;  4'hA: dig = 4'h9;  4'hB: dig = 4'hC;
      4'hC: dig = 4'hE;  4'hD: dig = 4'h0;  4'hE: dig = 4'hF;  default: dig = 4'hD;
    endcase
    return dig;
  endfunction

  // The first two dwell cycles after a column change still hold rows sampled
  // under the previous column, so they are masked out.
  assign detect    = (dwell_q >= DW'(2)) && (rs_q != 4'hF);
  assign cols_next = {cols_q[2:0], cols_q[3]};

  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    dwell_d     = dwell_q;
    dbcnt_d     = dbcnt_q;
    pat_d       = pat_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    key_valid_d = 1'b0;

    case (state_q)
      ST_SCAN: begin
        // Detection wins over rotation so the column stays on the pressed key.
        if (detect) begin
          pat_d   = rs_q;
          dbcnt_d = '0;
          state_d = ST_PRESS_DB;
        end else if (dwell_q == DWELL_LAST) begin
          cols_d  = cols_next;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_PRESS_DB: begin
        if (rs_q == pat_q) begin
          if (dbcnt_q == DB_LAST) begin
            s1_d        = s2_q;
            s2_d        = decode(pat_q, cols_q);
            key_valid_d = 1'b1;
            state_d     = ST_HELD;
          end else begin
            dbcnt_d = dbcnt_q + BW'(1);
          end
        end else begin
          dwell_d = '0;
          state_d = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (rs_q == 4'hF) begin
          dbcnt_d = '0;
          state_d = ST_REL_DB;
        end
      end
      default: begin // ST_REL_DB
        if (rs_q == 4'hF) begin
          if (dbcnt_q == DB_LAST) begin
            cols_d  = cols_next;
            dwell_d = '0;
            state_d = ST_SCAN;
          end else begin
            dbcnt_d = dbcnt_q + BW'(1);
          end
        end else begin
          state_d = ST_HELD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 4'hF;
      rs_q        <= 4'hF;
      state_q     <= ST_SCAN;
      cols_q      <= 4'b1110;
      dwell_q     <= '0;
      dbcnt_q     <= '0;
      pat_q       <= 4'hF;
      s1_q        <= 4'h0;
      s2_q        <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      sync1_q     <= rows;
      rs_q        <= sync1_q;
      state_q     <= state_d;
      cols_q      <= cols_d;
      dwell_q     <= dwell_d;
      dbcnt_q     <= dbcnt_d;
      pat_q       <= pat_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign cols        = cols_q;
  assign s1          = s1_q;
  assign s2          = s2_q;
  assign key_valid   = key_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_CYCLES=8 and DEBOUNCE_CYCLES=4.
// The keypad model pulls row r low while key (r,c) is down and cols[c] is low.
// Expected {s1,s2} pairs are pushed when a press is issued. A forked monitor
// pops and compares one pair on every key_valid pulse.
module tb_keypad_scanner;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  logic       clk;
  logic       reset;
  logic [3:0] rows_w;
  logic [3:0] cols;
  logic [3:0] s1;
  logic [3:0] s2;
  logic       key_valid;
  logic [1:0] dbg_state;

  logic [15:0] key_down;
  logic [7:0]  exp_q[$];
  int          n_vec;
  int          n_err;

  keypad_scanner #(.SCAN_CYCLES(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows_w),
    .cols        (cols),
    .s1          (s1),
    .s2          (s2),
    .key_valid   (key_valid),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad matrix model
  always_comb begin
    rows_w = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !cols[c]) rows_w[r] = 1'b0;
  end

  // driver tasks
  task automatic set_key(input int r, input int c, input logic down);
    key_down[r*4+c] = down;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no key_valid within 200 cycles, %0d pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input string name, input logic [1:0] st);
    int t;
    t = 0;
    while (dbg_state !== st && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (dbg_state !== st) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: state %0d, wanted %0d within 100 cycles", name, dbg_state, st);
    end
  endtask

  // scoreboard monitor: every pulse must match the oldest expected pair
  task automatic monitor();
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: s1=%h s2=%h with no press pending", s1, s2);
        end else begin
          exp = exp_q.pop_front();
          check("pulse_digits", {s1, s2}, exp);
        end
      end
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    key_down = '0;
    reset    = 1'b0;
    fork
      monitor();
    join_none

    // reset held 3 cycles with "5" pressed
    set_key(1, 1, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_cols", {4'h0, cols}, 8'h0E);
    check("rst_s1", {4'h0, s1}, 8'h00);
    check("rst_s2", {4'h0, s2}, 8'h00);
    check("rst_kv", {7'h0, key_valid}, 8'h00);
    reset = 1'b1;
    set_key(1, 1, 1'b0);
    @(negedge clk);
    check("post_rst_kv", {7'h0, key_valid}, 8'h00);
    repeat (5) @(negedge clk);

    // clean "5", release, clean "C"
    exp_q.push_back({4'h0, 4'h5});
    set_key(1, 1, 1'b1);
    wait_drain("press_5");
    set_key(1, 1, 1'b0);
    repeat (30) @(negedge clk);
    check("idle_after_5", {6'h0, dbg_state}, {6'h0, ST_SCAN});
    exp_q.push_back({4'h5, 4'hC});
    set_key(2, 3, 1'b1);
    wait_drain("press_C");
    set_key(2, 3, 1'b0);
    repeat (30) @(negedge clk);

    // bouncy "A": toggles every 2 cycles for 20 cycles, then stable
    exp_q.push_back({4'hC, 4'hA});
    for (int k = 0; k < 10; k++) begin
      set_key(0, 3, (k % 2 == 0));
      repeat (2) @(negedge clk);
    end
    set_key(0, 3, 1'b1);
    wait_drain("bouncy_A");
    repeat (3) @(negedge clk);
    check("held_A_state", {6'h0, dbg_state}, {6'h0, ST_HELD});
    check("held_A_cols", {4'h0, cols}, 8'h07);

    // bouncy release: key returns while REL_DB is still counting
    set_key(0, 3, 1'b0);
    wait_state("enter_rel_db", ST_REL_DB);
    set_key(0, 3, 1'b1);
    repeat (4) @(negedge clk);
    check("rel_bounce_state", {6'h0, dbg_state}, {6'h0, ST_HELD});
    check("rel_bounce_cols", {4'h0, cols}, 8'h07);
    check("rel_bounce_s2", {4'h0, s2}, 8'h0A);
    set_key(0, 3, 1'b0);
    repeat (30) @(negedge clk);

    // "0" held 1000 cycles, "7" added meanwhile, both released
    exp_q.push_back({4'hA, 4'h0});
    set_key(3, 1, 1'b1);
    wait_drain("press_0");
    repeat (1000) @(negedge clk);
    set_key(2, 0, 1'b1);
    repeat (50) @(negedge clk);
    check("held0_s1", {4'h0, s1}, 8'h0A);
    check("held0_s2", {4'h0, s2}, 8'h00);
    check("held0_cols", {4'h0, cols}, 8'h0D);
    set_key(3, 1, 1'b0);
    set_key(2, 0, 1'b0);
    repeat (30) @(negedge clk);
    check("after0_s2", {4'h0, s2}, 8'h00);
    exp_q.push_back({4'h0, 4'h7});
    set_key(2, 0, 1'b1);
    wait_drain("press_7");
    set_key(2, 0, 1'b0);
    repeat (30) @(negedge clk);

    // reset during PRESS_DB of "9"
    set_key(2, 2, 1'b1);
    wait_state("enter_press_db_9", ST_PRESS_DB);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_s1", {4'h0, s1}, 8'h00);
    check("midrst_s2", {4'h0, s2}, 8'h00);
    check("midrst_cols", {4'h0, cols}, 8'h0E);
    check("midrst_kv", {7'h0, key_valid}, 8'h00);
    check("midrst_state", {6'h0, dbg_state}, {6'h0, ST_SCAN});
    reset = 1'b1;
    set_key(2, 2, 1'b0);
    repeat (10) @(negedge clk);
    exp_q.push_back({4'h0, 4'h9});
    set_key(2, 2, 1'b1);
    wait_drain("repress_9");
    set_key(2, 2, 1'b0);
    repeat (30) @(negedge clk);
    check("final_s1", {4'h0, s1}, 8'h00);
    check("final_s2", {4'h0, s2}, 8'h09);
    check("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, debounces presses and releases, and registers exactly one new hex digit per physical key press. It sits directly upstream of the dual 7-segment display driver. It holds the two most recent digits as `s1` (older) and `s2` (newest) and presents them straight to that driver's digit inputs. Asynchronous row inputs are synchronized internally.

## Interface
Parameters:
- `SCAN_CYCLES`, default 4800: dwell per column in clock cycles (100 µs at 48 MHz); must be ≥ 4.
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required for press or release (5 ms at 48 MHz); must be ≥ 1.

Ports:
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `rows`, input, 4: keypad rows; active-low, externally pulled up; asynchronous.
- `cols`, output, 4: keypad column drive, active-low, one-hot-low while scanning.
- `s1`, output, 4: previously entered digit.
- `s2`, output, 4: most recently entered digit.
- `key_valid`, output, 1: one-cycle pulse on each accepted press.

## Operation
- Synchronizer:
  - Two-flop synchronizer on `rows`; both stages reset to 4'hF.
  - `rs` denotes the second-stage output.
- Key map, row i / col j → digit:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
  - If several rows are low, the lowest row index wins.
- States: SCAN, PRESS_DB, HELD, REL_DB. Reset enters SCAN.
- SCAN:
  - `dwell` increments each cycle.
  - At `dwell == SCAN_CYCLES-1`, rotate `cols` (1110→1101→1011→0111→1110) and clear `dwell`.
  - Detection is enabled only when `dwell ≥ 2`, which allows for synchronizer settling after a column change.
  - If `rs != 4'hF` and detection is enabled: capture `rs` into `pat`, clear `dbcnt`, freeze `cols`, and go to PRESS_DB.
- PRESS_DB:
  - If `rs == pat` and `dbcnt == DEBOUNCE_CYCLES-1`, commit: `s1 <= s2`, `s2 <= decode(pat, col)`, assert `key_valid`, go to HELD.
  - If `rs == pat` otherwise, increment `dbcnt`.
  - If `rs != pat`, return to SCAN with the same column and `dwell` cleared. No digit change.
- HELD:
  - Stay while `rs != 4'hF`. Other keys pressed meanwhile are ignored.
  - On `rs == 4'hF`, clear `dbcnt` and go to REL_DB.
- REL_DB:
  - If `rs == 4'hF` and `dbcnt == DEBOUNCE_CYCLES-1`, go to SCAN, advance to the next column, clear `dwell`.
  - If `rs == 4'hF` otherwise, increment `dbcnt`.
  - If `rs != 4'hF`, return to HELD (bounce) with no new digit.
- Counter widths: `$clog2` of the respective parameter; no wrap occurs inside a state.
- Reset:
  - Applies mid-operation from any state: next edge gives SCAN, `cols = 4'b1110`, `dwell = 0`, `dbcnt = 0`.
  - `s1 = s2 = 4'h0`, `key_valid = 0`.

## Timing
- Reset values:
  - `cols = 4'b1110`, `s1 = 4'h0`, `s2 = 4'h0`, `key_valid = 0`.
  - All outputs are registered.
- Press latency, from the first edge sampling a low row with detection enabled:
  - 2 edges for synchronization.
  - 1 edge for SCAN→PRESS_DB.
  - `DEBOUNCE_CYCLES` edges to commit.
  - `s1`, `s2` and `key_valid` update on that same commit edge.
- `key_valid` is high for exactly one cycle per accepted press.
  - Minimum spacing between pulses: 2·`DEBOUNCE_CYCLES`+3 cycles.
- `cols` is constant from PRESS_DB entry until REL_DB exit.
- A full scan of all four columns takes 4·`SCAN_CYCLES` cycles when idle.

## Test plan
Bench settings: `SCAN_CYCLES=8`, `DEBOUNCE_CYCLES=4`. The keypad model pulls row i low while key (i,j) is pressed and `cols[j]` is low.

- Reset: hold `reset=0` for 3 cycles with a key pressed → `cols=1110`, `s1=s2=0`, `key_valid=0`; no pulse in the cycle after release of reset.
- Clean press of "5", then release, then clean press of "C" → after the first press `key_valid` pulses once and `s2=5`, `s1=0`; after the second `s2=C`, `s1=5`.
- Bouncy press of "A", row toggling every 2 cycles for 20 cycles then stable → exactly one `key_valid` pulse, `s2=A`.
- Bouncy release, rows returning low 2 cycles into REL_DB → no extra pulse, state returns to HELD, `cols` frozen.
- Key "0" held for 1000 cycles, then "7" pressed while "0" is still held, then both released → one pulse only, `s2=0`; "7" is accepted only after a full release and a new press.
- Reset asserted during PRESS_DB of "9" → `s1=s2=0`, `cols=1110` on the next edge, no pulse; after re-press "9" is accepted normally.
